// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: stall-bus layout, stall levels and FSM encodings for the data-memory controller
package data_mem_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int MEMC_TIMEOUT = 255;
  typedef enum logic [1:0] {
    MEMC_IDLE = 2'd0,
    MEMC_REQ  = 2'd1,
    MEMC_WAIT = 2'd2,
    MEMC_HOLD = 2'd3
  } memc_state_e;
endpackage

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sequences EX loads/stores onto a req/addr_ok/data_ok bus, stalls while busy, holds the load word for MEM
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = MEMC_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_req,
  input  logic               ex_wr,
  input  logic [3:0]         ex_wstrb,
  input  logic [ADDR_W-1:0]  ex_addr,
  input  logic [DATA_W-1:0]  ex_wdata,
  output logic               data_req,
  output logic               data_wr,
  output logic [3:0]         data_wstrb,
  output logic [ADDR_W-1:0]  data_addr,
  output logic [DATA_W-1:0]  data_wdata,
  input  logic               data_addr_ok,
  input  logic               data_data_ok,
  input  logic [DATA_W-1:0]  data_rdata,
  output logic               stallreq_mem,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_rdata_vld,
  output logic               bus_err
);
  memc_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic wr_q, wr_d, vld_q, vld_d, err_q, err_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic hold_exit, accept, done, timeout;
  logic unused;
  assign unused = ^{stall[STALL_W-1:4], stall[1:0], ex_addr[1:0]};
  always_comb begin
    hold_exit = state_q == MEMC_HOLD && stall[3] == NO_STOP;
    accept = ex_req && stall[2] == NO_STOP && (state_q == MEMC_IDLE || hold_exit);
    done = data_data_ok && (state_q == MEMC_WAIT || (state_q == MEMC_REQ && data_addr_ok));
    timeout = state_q == MEMC_WAIT && !data_data_ok && cnt_q + 8'd1 == TIMEOUT[7:0];
    state_d = state_q;
    unique case (state_q)
      MEMC_IDLE: state_d = accept ? MEMC_REQ : MEMC_IDLE;
      MEMC_REQ:  state_d = done ? MEMC_HOLD : data_addr_ok ? MEMC_WAIT : MEMC_REQ;
      MEMC_WAIT: state_d = (done || timeout) ? MEMC_HOLD : MEMC_WAIT;
      MEMC_HOLD: state_d = !hold_exit ? MEMC_HOLD : accept ? MEMC_REQ : MEMC_IDLE;
    endcase
    wr_d = accept ? ex_wr : wr_q;
    wstrb_d = accept ? (ex_wr ? ex_wstrb : 4'd0) : wstrb_q;
    addr_d = accept ? {ex_addr[ADDR_W-1:2], 2'b00} : addr_q;
    wdata_d = accept ? ex_wdata : wdata_q;
    cnt_d = accept ? 8'd0 : state_q == MEMC_WAIT ? cnt_q + 8'd1 : cnt_q;
    rdata_d = timeout ? '0 : (done && !wr_q) ? data_rdata : rdata_q;
    vld_d = (hold_exit || timeout) ? 1'b0 : (done && !wr_q) ? 1'b1 : vld_q;
    err_d = err_q || timeout;
    stallreq_mem = state_q == MEMC_REQ || state_q == MEMC_WAIT || (state_q == MEMC_IDLE && accept);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEMC_IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      wstrb_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end
  assign data_req = state_q == MEMC_REQ;
  assign data_wr = wr_q;
  assign data_wstrb = wstrb_q;
  assign data_addr = addr_q;
  assign data_wdata = wdata_q;
  assign mem_rdata = rdata_q;
  assign mem_rdata_vld = vld_q;
  assign bus_err = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized transaction bench for data_mem_ctrl against a byte-merging memory model
module tb_data_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] stall = '0;
  logic ex_req = 1'b0, ex_wr = 1'b0;
  logic [3:0] ex_wstrb = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic data_req, data_wr, stallreq_mem, mem_rdata_vld, bus_err;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata, mem_rdata;
  logic data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  int checks = 0, failures = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] bus_mem [int];
  logic [31:0] exp_rdata = '0;
  logic exp_err = 1'b0;
  bit in_hold = 1'b0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_req(ex_req), .ex_wr(ex_wr), .ex_wstrb(ex_wstrb), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .stallreq_mem(stallreq_mem), .mem_rdata(mem_rdata),
    .mem_rdata_vld(mem_rdata_vld), .bus_err(bus_err)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] seed_word(input int k);
    return 32'(k) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  function automatic logic [31:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : seed_word(k);
  endfunction

  function automatic logic [31:0] bus_rd(input int k);
    return bus_mem.exists(k) ? bus_mem[k] : seed_word(k);
  endfunction

  task automatic noise();
    ex_req = 1'($urandom);
    ex_wr = 1'($urandom);
    ex_wstrb = 4'($urandom);
    ex_addr = $urandom;
    ex_wdata = $urandom;
    stall = 6'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data_req"}, 32'(data_req), 0);
    chk({tag, "_data_wr"}, 32'(data_wr), 0);
    chk({tag, "_data_wstrb"}, 32'(data_wstrb), 0);
    chk({tag, "_data_addr"}, data_addr, 0);
    chk({tag, "_data_wdata"}, data_wdata, 0);
    chk({tag, "_stallreq"}, 32'(stallreq_mem), 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_vld"}, 32'(mem_rdata_vld), 0);
    chk({tag, "_bus_err"}, 32'(bus_err), 0);
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input int a_dly, input int d_dly, input int hold);
    logic [31:0] wa, rsp, exp_ld;
    logic [3:0] es;
    int sr, k, kb;
    bit fh;
    fh = in_hold;
    wa = addr & ~32'd3;
    es = wr ? strb : 4'd0;
    k = int'(wa >> 2);
    rsp = '0;
    exp_ld = ref_rd(k);
    ex_req = 1'b1; ex_wr = wr; ex_wstrb = strb; ex_addr = addr; ex_wdata = wd;
    stall = 6'($urandom) & 6'b110011;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("accept_stallreq", 32'(stallreq_mem), fh ? 0 : 1);
    sr = int'(stallreq_mem);
    if (wr) ref_mem[k] = merge(ref_rd(k), wd, strb);
    @(negedge clk);
    for (int i = 0; i <= a_dly; i++) begin
      chk("req_valid", 32'(data_req), 1);
      chk("req_addr", data_addr, wa);
      chk("req_wr", 32'(data_wr), 32'(wr));
      chk("req_wstrb", 32'(data_wstrb), 32'(es));
      if (wr) chk("req_wdata", data_wdata, wd);
      if (i == 0) chk("req_vld_clear", 32'(mem_rdata_vld), 0);
      noise();
      data_addr_ok = i == a_dly;
      if (data_addr_ok) begin
        kb = int'(data_addr >> 2);
        if (data_wr) bus_mem[kb] = merge(bus_rd(kb), data_wdata, data_wstrb);
        else rsp = bus_rd(kb);
      end
      data_data_ok = data_addr_ok && d_dly == 0;
      data_rdata = data_data_ok ? rsp : $urandom;
      #1 sr += int'(stallreq_mem);
      @(negedge clk);
    end
    for (int i = 1; i <= d_dly; i++) begin
      chk("wait_bus_idle", 32'(data_req), 0);
      noise();
      data_addr_ok = 1'($urandom);
      data_data_ok = i == d_dly;
      data_rdata = data_data_ok ? rsp : $urandom;
      #1 sr += int'(stallreq_mem);
      @(negedge clk);
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; ex_req = 1'b0; stall = 6'b001000;
    chk("stall_cycles", sr, (fh ? 0 : 1) + a_dly + 1 + d_dly);
    if (!wr) exp_rdata = exp_ld;
    for (int i = 0; i <= hold; i++) begin
      chk("hold_rdata", mem_rdata, exp_rdata);
      chk("hold_vld", 32'(mem_rdata_vld), 32'(!wr));
      chk("hold_stallreq", 32'(stallreq_mem), 0);
      chk("hold_bus_idle", 32'(data_req), 0);
      chk("hold_err", 32'(bus_err), 32'(exp_err));
      if (i < hold) begin
        noise();
        stall[3] = 1'b1;
        data_data_ok = 1'($urandom);
        data_rdata = $urandom;
        @(negedge clk);
      end
    end
    ex_req = 1'b0; data_data_ok = 1'b0; stall = 6'b001000;
    in_hold = 1'b1;
  endtask

  task automatic release_hold();
    stall = 6'($urandom) & 6'b110111;
    ex_req = 1'b0;
    @(negedge clk);
    chk("idle_vld_clear", 32'(mem_rdata_vld), 0);
    chk("idle_stallreq", 32'(stallreq_mem), 0);
    chk("idle_rdata", mem_rdata, exp_rdata);
    data_data_ok = 1'b1;
    data_rdata = $urandom;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("idle_stray_vld", 32'(mem_rdata_vld), 0);
    chk("idle_stray_rdata", mem_rdata, exp_rdata);
    chk("idle_noreq", 32'(data_req), 0);
    in_hold = 1'b0;
  endtask

  task automatic timeout_case();
    int n;
    if (in_hold) release_hold();
    ex_req = 1'b1; ex_wr = 1'b0; ex_addr = 32'h80; ex_wstrb = 4'hF; stall = '0;
    @(negedge clk);
    ex_req = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    n = 0;
    while (stallreq_mem && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 4);
    exp_err = 1'b1;
    exp_rdata = '0;
    chk("timeout_err", 32'(bus_err), 1);
    chk("timeout_rdata", mem_rdata, 0);
    chk("timeout_vld", 32'(mem_rdata_vld), 0);
    stall = 6'b001000;
    in_hold = 1'b1;
  endtask

  task automatic reset_mid();
    if (in_hold) release_hold();
    ex_req = 1'b1; ex_wr = 1'b0; ex_addr = 32'h44; ex_wstrb = 4'h0; stall = '0;
    @(negedge clk);
    ex_req = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    chk("mid_in_wait", 32'(stallreq_mem), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_mid");
    data_data_ok = 1'b1;
    data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    data_data_ok = 1'b0;
    chk("late_ok_vld", 32'(mem_rdata_vld), 0);
    chk("late_ok_rdata", mem_rdata, 0);
    chk("late_ok_stallreq", 32'(stallreq_mem), 0);
    chk("late_ok_noreq", 32'(data_req), 0);
    exp_rdata = '0;
    exp_err = 1'b0;
    in_hold = 1'b0;
  endtask

  task automatic rand_access();
    if (in_hold && $urandom_range(0, 1) == 1) release_hold();
    access(1'($urandom), 32'($urandom_range(0, 63)), 4'($urandom), $urandom,
           $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    ex_req = 1'b1; ex_wr = 1'b0; ex_addr = 32'h10; stall = 6'b000100;
    #1 chk("blocked_stallreq", 32'(stallreq_mem), 0);
    @(negedge clk);
    chk("blocked_noreq", 32'(data_req), 0);
    ex_req = 1'b0; stall = '0;
    bus_mem[int'(32'h1004 >> 2)] = 32'hA1B2C3D4;
    ref_mem[int'(32'h1004 >> 2)] = 32'hA1B2C3D4;
    access(1'b0, 32'h0000_1006, 4'hF, 32'h0, 0, 2, 0);
    chk("load_word", mem_rdata, 32'hA1B2C3D4);
    release_hold();
    access(1'b1, 32'h20, 4'b1100, 32'h55660000, 0, 0, 0);
    release_hold();
    bus_mem[int'(32'h60 >> 2)] = 32'h12345678;
    ref_mem[int'(32'h60 >> 2)] = 32'h12345678;
    access(1'b0, 32'h60, 4'h0, 32'h0, 1, 1, 3);
    access(1'b0, 32'h40, 4'h0, 32'h0, 0, 1, 0);
    access(1'b0, 32'h22, 4'h0, 32'h0, 0, 0, 1);
    chk("store_then_load", mem_rdata, merge(seed_word(8), 32'h55660000, 4'b1100));
    for (int t = 0; t < 40; t++) rand_access();
    timeout_case();
    rand_access();
    if (in_hold) release_hold();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_clear");
    exp_err = 1'b0;
    exp_rdata = '0;
    in_hold = 1'b0;
    reset_mid();
    for (int t = 0; t < 10; t++) rand_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
